// File: rtl/wt_dcache_miss_resp.sv
// Miss responder for the write-through dcache read ports: arbitrates port misses, tracks one
// outstanding line fill (MSHR), issues the memory read and writes the returned line into the cache.
module wt_dcache_miss_resp #(
   parameter int NumPorts = 3,
   parameter int PlenW    = 56,
   parameter int SetAssoc = 8,
   parameter int OffsetW  = 4,
   parameter int LineW    = 128,
   parameter int IdW      = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NumPorts-1:0]          miss_req_i,
   input  logic [NumPorts*PlenW-1:0]    miss_paddr_i,
   input  logic [NumPorts-1:0]          miss_nc_i,
   input  logic [NumPorts*3-1:0]        miss_size_i,
   input  logic [NumPorts*SetAssoc-1:0] miss_vld_bits_i,
   input  logic [NumPorts*IdW-1:0]      miss_id_i,
   output logic [NumPorts-1:0]          miss_ack_o,
   output logic [NumPorts-1:0]          miss_replay_o,
   output logic [NumPorts-1:0]          miss_rtrn_vld_o,
   output logic                         mem_req_o,
   input  logic                         mem_gnt_i,
   output logic [PlenW-1:0]             mem_paddr_o,
   output logic [2:0]                   mem_size_o,
   output logic                         mem_nc_o,
   output logic [IdW-1:0]               mem_id_o,
   input  logic                         mem_rtrn_vld_i,
   input  logic [IdW-1:0]               mem_rtrn_id_i,
   input  logic [LineW-1:0]             mem_rtrn_data_i,
   output logic                         wr_cl_vld_o,
   output logic [SetAssoc-1:0]          wr_cl_way_o,
   output logic [12-OffsetW-1:0]        wr_cl_idx_o,
   output logic [PlenW-12-1:0]          wr_cl_tag_o,
   output logic [LineW-1:0]             wr_cl_data_o,
   output logic                         busy_o
);

   localparam int PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int CandW = PortW + 1;
   localparam int WayW  = (SetAssoc > 1) ? $clog2(SetAssoc) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_REQ  = 2'd1,
      MEM_WAIT = 2'd2
   } state_e;

   state_e               state_r, state_s;
   logic [PortW-1:0]     rr_ptr_r, rr_next_s, win_port_s, mshr_port_r;
   logic [CandW-1:0]     cand_s;
   logic                 win_vld_s, accept_s, rtrn_hit_s, all_vld_s;
   logic [SetAssoc-1:0]  sel_vld_bits_s, way_s;
   logic [PlenW-1:0]     mshr_paddr_r;
   logic                 mshr_nc_r;
   logic [2:0]           mshr_size_r;
   logic [SetAssoc-1:0]  mshr_way_r;
   logic [IdW-1:0]       mshr_id_r;
   logic [7:0]           lfsr_r;

   // round-robin pick of the first requesting port at or after the pointer
   always_comb begin
      win_vld_s  = 1'b0;
      win_port_s = '0;
      cand_s     = '0;
      for (int i = 0; i < NumPorts; i++) begin
         cand_s = {1'b0, rr_ptr_r} + CandW'(i);
         if (cand_s >= CandW'(NumPorts)) begin
            cand_s = cand_s - CandW'(NumPorts);
         end else begin
            cand_s = cand_s;
         end
         if (!win_vld_s && miss_req_i[cand_s[PortW-1:0]]) begin
            win_vld_s  = 1'b1;
            win_port_s = cand_s[PortW-1:0];
         end else begin
            win_vld_s  = win_vld_s;
         end
      end
      if (win_port_s == PortW'(NumPorts - 1)) begin
         rr_next_s = '0;
      end else begin
         rr_next_s = win_port_s + PortW'(1);
      end
   end

   // victim way: lowest invalid way, otherwise pseudo-random from the LFSR
   always_comb begin
      sel_vld_bits_s = miss_vld_bits_i[win_port_s*SetAssoc +: SetAssoc];
      way_s          = '0;
      all_vld_s      = 1'b1;
      for (int i = 0; i < SetAssoc; i++) begin
         if (all_vld_s && !sel_vld_bits_s[i]) begin
            way_s[i]  = 1'b1;
            all_vld_s = 1'b0;
         end else begin
            all_vld_s = all_vld_s;
         end
      end
      if (all_vld_s) begin
         way_s = SetAssoc'(1) << lfsr_r[WayW-1:0];
      end else begin
         way_s = way_s;
      end
   end

   // FSM next state; reset suppresses accept and completion in the same cycle
   always_comb begin
      state_s    = state_r;
      accept_s   = 1'b0;
      rtrn_hit_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (win_vld_s && !rst_i) begin
               accept_s = 1'b1;
               state_s  = MEM_REQ;
            end else begin
               state_s  = IDLE;
            end
         end
         MEM_REQ: begin
            if (mem_gnt_i) begin
               state_s = MEM_WAIT;
            end else begin
               state_s = MEM_REQ;
            end
         end
         MEM_WAIT: begin
            if (mem_rtrn_vld_i && (mem_rtrn_id_i == mshr_id_r) && !rst_i) begin
               rtrn_hit_s = 1'b1;
               state_s    = IDLE;
            end else begin
               state_s    = MEM_WAIT;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // state, arbitration pointer, LFSR and MSHR capture
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= IDLE;
         rr_ptr_r     <= '0;
         lfsr_r       <= 8'hA5;
         mshr_port_r  <= '0;
         mshr_paddr_r <= '0;
         mshr_nc_r    <= 1'b0;
         mshr_size_r  <= 3'b000;
         mshr_way_r   <= '0;
         mshr_id_r    <= '0;
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            rr_ptr_r     <= rr_next_s;
            mshr_port_r  <= win_port_s;
            mshr_paddr_r <= miss_paddr_i[win_port_s*PlenW +: PlenW];
            mshr_nc_r    <= miss_nc_i[win_port_s];
            mshr_size_r  <= miss_size_i[win_port_s*3 +: 3];
            mshr_way_r   <= way_s;
            mshr_id_r    <= miss_id_i[win_port_s*IdW +: IdW];
            if (!miss_nc_i[win_port_s] && all_vld_s) begin
               lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
            end
         end
      end
   end

   // port handshakes, memory request and cacheline write
   always_comb begin
      miss_ack_o      = '0;
      miss_rtrn_vld_o = '0;
      miss_replay_o   = '0;
      if (accept_s) begin
         miss_ack_o[win_port_s] = 1'b1;
      end else begin
         miss_ack_o = '0;
      end
      if (rtrn_hit_s) begin
         miss_rtrn_vld_o[mshr_port_r] = 1'b1;
      end else begin
         miss_rtrn_vld_o = '0;
      end
      for (int p = 0; p < NumPorts; p++) begin
         miss_replay_o[p] = (state_r != IDLE) && !rst_i && miss_req_i[p] && !miss_nc_i[p]
                          && (miss_paddr_i[p*PlenW+OffsetW +: PlenW-OffsetW]
                              == mshr_paddr_r[PlenW-1:OffsetW])
                          && !(rtrn_hit_s && (mshr_port_r == PortW'(p)));
      end
      mem_req_o = (state_r == MEM_REQ);
      if (mem_req_o) begin
         mem_paddr_o = mshr_nc_r ? mshr_paddr_r : {mshr_paddr_r[PlenW-1:OffsetW], {OffsetW{1'b0}}};
         mem_size_o  = mshr_nc_r ? mshr_size_r : 3'b111;
         mem_nc_o    = mshr_nc_r;
         mem_id_o    = mshr_id_r;
      end else begin
         mem_paddr_o = '0;
         mem_size_o  = 3'b000;
         mem_nc_o    = 1'b0;
         mem_id_o    = '0;
      end
      wr_cl_vld_o = rtrn_hit_s && !mshr_nc_r;
      if (wr_cl_vld_o) begin
         wr_cl_way_o  = mshr_way_r;
         wr_cl_idx_o  = mshr_paddr_r[11:OffsetW];
         wr_cl_tag_o  = mshr_paddr_r[PlenW-1:12];
         wr_cl_data_o = mem_rtrn_data_i;
      end else begin
         wr_cl_way_o  = '0;
         wr_cl_idx_o  = '0;
         wr_cl_tag_o  = '0;
         wr_cl_data_o = '0;
      end
      busy_o = (state_r != IDLE);
   end

   wt_dcache_miss_resp_chk #(
      .NumPorts(NumPorts), .PlenW(PlenW), .SetAssoc(SetAssoc), .IdW(IdW)
   ) i_chk (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .miss_ack       (miss_ack_o),
      .miss_replay    (miss_replay_o),
      .miss_rtrn_vld  (miss_rtrn_vld_o),
      .wr_cl_way      (wr_cl_way_o),
      .mem_req        (mem_req_o),
      .mem_gnt        (mem_gnt_i),
      .mem_paddr      (mem_paddr_o),
      .mem_size       (mem_size_o),
      .mem_nc         (mem_nc_o),
      .mem_id         (mem_id_o)
   );

endmodule

// Protocol checker: handshake exclusivity, one-hot way and memory request stability.
module wt_dcache_miss_resp_chk #(
   parameter int NumPorts = 3,
   parameter int PlenW    = 56,
   parameter int SetAssoc = 8,
   parameter int IdW      = 2
) (
   input logic                clk_i,
   input logic                rst_i,
   input logic [NumPorts-1:0] miss_ack,
   input logic [NumPorts-1:0] miss_replay,
   input logic [NumPorts-1:0] miss_rtrn_vld,
   input logic [SetAssoc-1:0] wr_cl_way,
   input logic                mem_req,
   input logic                mem_gnt,
   input logic [PlenW-1:0]    mem_paddr,
   input logic [2:0]          mem_size,
   input logic                mem_nc,
   input logic [IdW-1:0]      mem_id
);
   a_ack_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(miss_ack));
   a_way_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(wr_cl_way));
   a_excl: assert property (@(posedge clk_i) disable iff (rst_i)
      ((miss_ack & miss_replay) | (miss_ack & miss_rtrn_vld) | (miss_replay & miss_rtrn_vld)) == '0);
   a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (mem_req && !mem_gnt) |=> (mem_req && $stable(mem_paddr) && $stable(mem_size)
                                 && $stable(mem_nc) && $stable(mem_id)));
endmodule

// File: tb/tb_wt_dcache_miss_resp.sv
// Directed bench for wt_dcache_miss_resp: reset, single fill, round-robin, replay, NC, grant stall, reset mid-miss.
module tb_wt_dcache_miss_resp;
   localparam int NP = 3, PW = 56, SA = 8, OW = 4, LW = 128, IW = 2;

   logic            clk = 1'b0;
   logic            rst_i;
   logic [NP-1:0]   miss_req, miss_nc, miss_ack, miss_replay, miss_rtrn_vld;
   logic [NP*PW-1:0] miss_paddr;
   logic [NP*3-1:0] miss_size;
   logic [NP*SA-1:0] miss_vld_bits;
   logic [NP*IW-1:0] miss_id;
   logic            mem_req, mem_gnt, mem_nc, mem_rtrn_vld, wr_cl_vld, busy;
   logic [PW-1:0]   mem_paddr;
   logic [2:0]      mem_size;
   logic [IW-1:0]   mem_id, mem_rtrn_id;
   logic [LW-1:0]   mem_rtrn_data, wr_cl_data;
   logic [SA-1:0]   wr_cl_way;
   logic [7:0]      wr_cl_idx;
   logic [PW-13:0]  wr_cl_tag;

   int checks = 0;
   int failures = 0;
   localparam logic [LW-1:0] DATA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

   always #5 clk = ~clk;

   wt_dcache_miss_resp dut (
      .clk_i(clk), .rst_i(rst_i),
      .miss_req_i(miss_req), .miss_paddr_i(miss_paddr), .miss_nc_i(miss_nc),
      .miss_size_i(miss_size), .miss_vld_bits_i(miss_vld_bits), .miss_id_i(miss_id),
      .miss_ack_o(miss_ack), .miss_replay_o(miss_replay), .miss_rtrn_vld_o(miss_rtrn_vld),
      .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_paddr_o(mem_paddr), .mem_size_o(mem_size),
      .mem_nc_o(mem_nc), .mem_id_o(mem_id), .mem_rtrn_vld_i(mem_rtrn_vld),
      .mem_rtrn_id_i(mem_rtrn_id), .mem_rtrn_data_i(mem_rtrn_data),
      .wr_cl_vld_o(wr_cl_vld), .wr_cl_way_o(wr_cl_way), .wr_cl_idx_o(wr_cl_idx),
      .wr_cl_tag_o(wr_cl_tag), .wr_cl_data_o(wr_cl_data), .busy_o(busy)
   );

   task automatic set_req(input int p, input logic [PW-1:0] a, input logic nc,
                          input logic [2:0] sz, input logic [SA-1:0] vb, input logic [IW-1:0] id);
      miss_req[p] = 1'b1;
      miss_paddr[p*PW +: PW] = a;
      miss_nc[p] = nc;
      miss_size[p*3 +: 3] = sz;
      miss_vld_bits[p*SA +: SA] = vb;
      miss_id[p*IW +: IW] = id;
   endtask

   task automatic clr_inputs();
      miss_req = '0; miss_paddr = '0; miss_nc = '0; miss_size = '0;
      miss_vld_bits = '0; miss_id = '0; mem_gnt = 1'b0; mem_rtrn_vld = 1'b0;
      mem_rtrn_id = '0; mem_rtrn_data = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_i = 1'b1;
      clr_inputs();
      @(negedge clk);
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_i = 1'b1;
      clr_inputs();
      set_req(0, 56'h8000_1040, 1'b0, 3'd3, 8'h00, 2'd0);
      #1;
      checks++;
      if (miss_ack !== 3'b000) begin failures++; $display("FAIL reset_ack: got %b want 000", miss_ack); end
      @(negedge clk);
      #1;
      checks++;
      if ({busy, mem_req, wr_cl_vld, miss_rtrn_vld, miss_replay} !== 9'd0) begin
         failures++;
         $display("FAIL reset_outputs: busy=%b mem_req=%b wr_cl_vld=%b rtrn=%b replay=%b want all 0",
                  busy, mem_req, wr_cl_vld, miss_rtrn_vld, miss_replay);
      end
      miss_req = '0;
      rst_i = 1'b0;
   endtask

   task automatic test_single_fill();
      do_reset();
      @(negedge clk);
      set_req(0, 56'h8000_1040, 1'b0, 3'd3, 8'h0F, 2'd1);
      #1;
      checks++;
      if (miss_ack !== 3'b001) begin failures++; $display("FAIL t1_ack: got %b want 001", miss_ack); end
      @(negedge clk);
      miss_req[0] = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_paddr, mem_size, mem_nc, mem_id, busy} !== {1'b1, 56'h8000_1040, 3'd7, 1'b0, 2'd1, 1'b1}) begin
         failures++;
         $display("FAIL t1_memreq: got req=%b paddr=%h size=%0d nc=%b id=%0d busy=%b want 1 80001040 7 0 1 1",
                  mem_req, mem_paddr, mem_size, mem_nc, mem_id, busy);
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rtrn_vld = 1'b1; mem_rtrn_id = 2'd1; mem_rtrn_data = DATA;
      #1;
      checks++;
      if ({miss_rtrn_vld, wr_cl_vld, wr_cl_way, wr_cl_idx} !== {3'b001, 1'b1, 8'h10, 8'h04}) begin
         failures++;
         $display("FAIL t1_rtrn: got rtrn=%b wr=%b way=%h idx=%h want 001 1 10 04",
                  miss_rtrn_vld, wr_cl_vld, wr_cl_way, wr_cl_idx);
      end
      checks++;
      if ({wr_cl_tag, wr_cl_data} !== {44'h0000_0008_0001, DATA}) begin
         failures++; $display("FAIL t1_tagdata: got tag=%h data=%h want 80001 %h", wr_cl_tag, wr_cl_data, DATA);
      end
      @(negedge clk);
      mem_rtrn_vld = 1'b0;
      #1;
      checks++;
      if ({busy, miss_rtrn_vld, wr_cl_vld} !== 5'd0) begin
         failures++; $display("FAIL t1_idle: got busy=%b rtrn=%b wr=%b want 0", busy, miss_rtrn_vld, wr_cl_vld);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_ack;
      logic [7:0] exp_way [3];
      exp_way[0] = 8'h20; exp_way[1] = 8'h04; exp_way[2] = 8'h20;
      do_reset();
      @(negedge clk);
      for (int p = 0; p < NP; p++) set_req(p, 56'h8000_0000 + 56'(p * 256), 1'b0, 3'd3, 8'hFF, 2'(p));
      for (int k = 0; k < NP; k++) begin
         exp_ack = 3'b001 << k;
         #1;
         checks++;
         if (miss_ack !== exp_ack) begin failures++; $display("FAIL t2_ack%0d: got %b want %b", k, miss_ack, exp_ack); end
         @(negedge clk);
         miss_req[k] = 1'b0;
         #1;
         checks++;
         if ({miss_ack, miss_replay} !== 6'd0) begin
            failures++; $display("FAIL t2_stall%0d: got ack=%b replay=%b want 0", k, miss_ack, miss_replay);
         end
         mem_gnt = 1'b1;
         @(negedge clk);
         mem_gnt = 1'b0;
         mem_rtrn_vld = 1'b1; mem_rtrn_id = 2'(k);
         #1;
         checks++;
         if ({miss_rtrn_vld, wr_cl_way} !== {exp_ack, exp_way[k]}) begin
            failures++;
            $display("FAIL t2_rtrn%0d: got rtrn=%b way=%h want %b %h", k, miss_rtrn_vld, wr_cl_way, exp_ack, exp_way[k]);
         end
         @(negedge clk);
         mem_rtrn_vld = 1'b0;
      end
   endtask

   task automatic test_replay_back_to_back();
      do_reset();
      @(negedge clk);
      set_req(0, 56'h8000_1040, 1'b0, 3'd3, 8'h00, 2'd0);
      #1;
      checks++;
      if (miss_ack !== 3'b001) begin failures++; $display("FAIL t3_ack0: got %b want 001", miss_ack); end
      @(negedge clk);
      miss_req[0] = 1'b0;
      set_req(1, 56'h8000_1048, 1'b0, 3'd3, 8'h00, 2'd1);
      set_req(2, 56'h8000_2000, 1'b0, 3'd3, 8'h00, 2'd2);
      #1;
      checks++;
      if ({miss_replay, miss_ack} !== {3'b010, 3'b000}) begin
         failures++; $display("FAIL t3_replay: got replay=%b ack=%b want 010 000", miss_replay, miss_ack);
      end
      @(negedge clk);
      set_req(1, 56'h8000_1040, 1'b1, 3'd3, 8'h00, 2'd1);
      #1;
      checks++;
      if ({miss_replay, miss_ack} !== 6'd0) begin
         failures++; $display("FAIL t3_nc_noreplay: got replay=%b ack=%b want 000 000", miss_replay, miss_ack);
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      set_req(1, 56'h8000_1048, 1'b0, 3'd3, 8'h00, 2'd1);
      mem_rtrn_vld = 1'b1; mem_rtrn_id = 2'd0;
      #1;
      checks++;
      if ({miss_rtrn_vld, miss_replay, miss_ack} !== {3'b001, 3'b010, 3'b000}) begin
         failures++;
         $display("FAIL t3_rtrn_cycle: got rtrn=%b replay=%b ack=%b want 001 010 000", miss_rtrn_vld, miss_replay, miss_ack);
      end
      @(negedge clk);
      mem_rtrn_vld = 1'b0;
      miss_req[1] = 1'b0;
      #1;
      checks++;
      if (miss_ack !== 3'b100) begin failures++; $display("FAIL t3_b2b_ack: got %b want 100", miss_ack); end
      @(negedge clk);
      miss_req[2] = 1'b0;
   endtask

   task automatic test_noncacheable();
      do_reset();
      @(negedge clk);
      set_req(1, 56'h1000_0004, 1'b1, 3'd2, 8'h00, 2'd3);
      #1;
      checks++;
      if (miss_ack !== 3'b010) begin failures++; $display("FAIL t4_ack: got %b want 010", miss_ack); end
      @(negedge clk);
      miss_req[1] = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_paddr, mem_size, mem_nc, mem_id} !== {1'b1, 56'h1000_0004, 3'd2, 1'b1, 2'd3}) begin
         failures++;
         $display("FAIL t4_memreq: got req=%b paddr=%h size=%0d nc=%b id=%0d want 1 10000004 2 1 3",
                  mem_req, mem_paddr, mem_size, mem_nc, mem_id);
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rtrn_vld = 1'b1; mem_rtrn_id = 2'd3;
      #1;
      checks++;
      if ({miss_rtrn_vld, wr_cl_vld} !== {3'b010, 1'b0}) begin
         failures++; $display("FAIL t4_rtrn: got rtrn=%b wr=%b want 010 0", miss_rtrn_vld, wr_cl_vld);
      end
      @(negedge clk);
      mem_rtrn_vld = 1'b0;
   endtask

   task automatic test_gnt_stall_and_id();
      do_reset();
      @(negedge clk);
      set_req(2, 56'h8000_305C, 1'b0, 3'd3, 8'h01, 2'd2);
      #1;
      checks++;
      if (miss_ack !== 3'b100) begin failures++; $display("FAIL t5_ack: got %b want 100", miss_ack); end
      @(negedge clk);
      miss_req[2] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if ({mem_req, mem_paddr, mem_size, mem_id} !== {1'b1, 56'h8000_3050, 3'd7, 2'd2}) begin
            failures++;
            $display("FAIL t5_hold%0d: got req=%b paddr=%h size=%0d id=%0d want 1 80003050 7 2",
                     i, mem_req, mem_paddr, mem_size, mem_id);
         end
         @(negedge clk);
      end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rtrn_vld = 1'b1; mem_rtrn_id = 2'd1;
      #1;
      checks++;
      if ({miss_rtrn_vld, wr_cl_vld, busy} !== {3'b000, 1'b0, 1'b1}) begin
         failures++; $display("FAIL t5_wrong_id: got rtrn=%b wr=%b busy=%b want 000 0 1", miss_rtrn_vld, wr_cl_vld, busy);
      end
      @(negedge clk);
      mem_rtrn_id = 2'd2;
      #1;
      checks++;
      if ({miss_rtrn_vld, wr_cl_vld, wr_cl_way} !== {3'b100, 1'b1, 8'h02}) begin
         failures++;
         $display("FAIL t5_right_id: got rtrn=%b wr=%b way=%h want 100 1 02", miss_rtrn_vld, wr_cl_vld, wr_cl_way);
      end
      @(negedge clk);
      mem_rtrn_vld = 1'b0;
   endtask

   task automatic test_reset_mid_miss();
      do_reset();
      @(negedge clk);
      set_req(0, 56'h8000_4000, 1'b0, 3'd3, 8'h00, 2'd0);
      #1;
      checks++;
      if (miss_ack !== 3'b001) begin failures++; $display("FAIL t6_ack: got %b want 001", miss_ack); end
      @(negedge clk);
      miss_req[0] = 1'b0;
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      #1;
      checks++;
      if ({busy, mem_req} !== 2'b10) begin failures++; $display("FAIL t6_wait: got busy=%b req=%b want 1 0", busy, mem_req); end
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      checks++;
      if ({busy, mem_req, miss_ack} !== 5'd0) begin
         failures++; $display("FAIL t6_after_rst: got busy=%b req=%b ack=%b want 0", busy, mem_req, miss_ack);
      end
      mem_rtrn_vld = 1'b1; mem_rtrn_id = 2'd0;
      #1;
      checks++;
      if ({miss_rtrn_vld, wr_cl_vld} !== 4'd0) begin
         failures++; $display("FAIL t6_stale_rtrn: got rtrn=%b wr=%b want 000 0", miss_rtrn_vld, wr_cl_vld);
      end
      @(negedge clk);
      mem_rtrn_vld = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      clr_inputs();
      test_reset();
      test_single_fill();
      test_round_robin();
      test_replay_back_to_back();
      test_noncacheable();
      test_gnt_stall_and_id();
      test_reset_mid_miss();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
